// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-slot alarm engine.
// Holds the FSM state encoding, time-field limits and the slot arbitration helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  localparam int HOURS_MAX   = 23;
  localparam int MINUTES_MAX = 59;
  localparam int HOUR_W      = 5;
  localparam int MIN_W       = 6;
  localparam int DAY_W       = 7;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Time, slot-write, user-input and status signals of the alarm engine.
// Optional ALARM_DAY_MASK_EN adds the weekday inputs.
interface multi_alarm_ctrl_if #(
  parameter int NUM_ALARMS = 4,
  parameter int IDX_W      = 2
);
  logic                  sec_tick;
  logic                  min_tick;
  logic [4:0]            cur_hours;
  logic [5:0]            cur_minutes;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [4:0]            wr_hours;
  logic [5:0]            wr_minutes;
  logic                  wr_arm;
  logic                  snooze;
  logic                  dismiss;
`ifdef ALARM_DAY_MASK_EN
  logic [2:0]            cur_day;
  logic [6:0]            wr_days;
`endif
  logic                  wr_err;
  logic [NUM_ALARMS-1:0] armed_mask;
  logic                  ringing;
  logic                  ring_blink;
  logic [IDX_W-1:0]      ring_idx;
  logic                  snoozed;
  logic [NUM_ALARMS-1:0] pending_mask;

  modport master (
`ifdef ALARM_DAY_MASK_EN
    output cur_day, wr_days,
`endif
    output sec_tick, min_tick, cur_hours, cur_minutes,
    output wr_en, wr_idx, wr_hours, wr_minutes, wr_arm, snooze, dismiss,
    input  wr_err, armed_mask, ringing, ring_blink, ring_idx, snoozed, pending_mask
  );

  modport slave (
`ifdef ALARM_DAY_MASK_EN
    input  cur_day, wr_days,
`endif
    input  sec_tick, min_tick, cur_hours, cur_minutes,
    input  wr_en, wr_idx, wr_hours, wr_minutes, wr_arm, snooze, dismiss,
    output wr_err, armed_mask, ringing, ring_blink, ring_idx, snoozed, pending_mask
  );
endinterface

// File: rtl/alarm_slot.sv
// One alarm slot: stored time, arm flag and (with ALARM_DAY_MASK_EN) a weekday mask.
// Write is pre-validated by the parent; match_o is combinational and ungated by min_tick.
module alarm_slot
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [HOUR_W-1:0] wr_hours_i,
  input  logic [MIN_W-1:0]  wr_minutes_i,
  input  logic              wr_arm_i,
  input  logic [HOUR_W-1:0] cur_hours_i,
  input  logic [MIN_W-1:0]  cur_minutes_i,
`ifdef ALARM_DAY_MASK_EN
  input  logic [DAY_W-1:0]  wr_days_i,
  input  logic [2:0]        cur_day_i,
`endif
  output logic              armed_o,
  output logic              match_o
);
  logic [HOUR_W-1:0] hours_q;
  logic [MIN_W-1:0]  minutes_q;
  logic              arm_q;
  logic              day_ok;

`ifdef ALARM_DAY_MASK_EN
  logic [DAY_W-1:0] days_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    days_q <= 7'h7F;
    else if (we_i) days_q <= wr_days_i;
  end

  assign day_ok = days_q[cur_day_i];
`else
  assign day_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hours_q   <= '0;
      minutes_q <= '0;
      arm_q     <= 1'b0;
    end else if (we_i) begin
      hours_q   <= wr_hours_i;
      minutes_q <= wr_minutes_i;
      arm_q     <= wr_arm_i;
    end
  end

  assign armed_o = arm_q;
  assign match_o = arm_q && day_ok && (hours_q == cur_hours_i) && (minutes_q == cur_minutes_i);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm engine: slots matched on min_tick, lowest-index arbitration, snooze/timeout FSM.
// Build with ALARM_DAY_MASK_EN to add per-slot weekday masks.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int IDX_W            = 2,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3,
  parameter int RING_TIMEOUT_SEC = 60
) (
  input logic               clk,
  input logic               rst_n,
  multi_alarm_ctrl_if.slave bus
);
  localparam int              SC_W         = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [SC_W-1:0] MAX_SNOOZE_C = SC_W'(MAX_SNOOZE);
  localparam logic [5:0]      SNOOZE_MIN_C = 6'(SNOOZE_MIN);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(RING_TIMEOUT_SEC - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ring_idx_q, ring_idx_d;
  logic [SC_W-1:0]       snooze_cnt_q, snooze_cnt_d;
  logic [5:0]            countdown_q, countdown_d;
  logic [7:0]            timeout_q, timeout_d;
  logic                  blink_q, blink_d;
  logic [NUM_ALARMS-1:0] pending_q, pending_d;
  logic                  wr_err_q;

  logic                  wr_days_ok, wr_ok, wr_valid;
  logic                  active_disarm, dismiss_evt, timeout_hit;
  logic [NUM_ALARMS-1:0] slot_we, slot_match, slot_armed;
  logic [NUM_ALARMS-1:0] active_mask, disarm_mask, new_match, pending_avail;

`ifdef ALARM_DAY_MASK_EN
  assign wr_days_ok = (bus.wr_days != '0);
`else
  assign wr_days_ok = 1'b1;
`endif

  assign wr_ok = (bus.wr_hours <= HOUR_W'(HOURS_MAX)) &&
                 (bus.wr_minutes <= MIN_W'(MINUTES_MAX)) &&
                 ({1'b0, bus.wr_idx} < (IDX_W + 1)'(NUM_ALARMS)) && wr_days_ok;
  assign wr_valid = bus.wr_en && wr_ok;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    assign slot_we[i] = wr_valid && (bus.wr_idx == IDX_W'(i));

    alarm_slot u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .we_i          (slot_we[i]),
      .wr_hours_i    (bus.wr_hours),
      .wr_minutes_i  (bus.wr_minutes),
      .wr_arm_i      (bus.wr_arm),
      .cur_hours_i   (bus.cur_hours),
      .cur_minutes_i (bus.cur_minutes),
`ifdef ALARM_DAY_MASK_EN
      .wr_days_i     (bus.wr_days),
      .cur_day_i     (bus.cur_day),
`endif
      .armed_o       (slot_armed[i]),
      .match_o       (slot_match[i])
    );
  end

  // The slot currently ringing or snoozed never re-queues itself.
  assign active_mask   = (state_q != IDLE) ? (NUM_ALARMS'(1) << ring_idx_q) : '0;
  assign disarm_mask   = (wr_valid && !bus.wr_arm) ? slot_we : '0;
  assign active_disarm = |(disarm_mask & active_mask);
  assign dismiss_evt   = bus.dismiss || active_disarm;
  assign new_match     = bus.min_tick ? (slot_match & ~active_mask) : '0;
  assign pending_avail = pending_q & ~disarm_mask;
  assign timeout_hit   = bus.sec_tick && (timeout_q == TIMEOUT_LAST);

  always_comb begin
    state_d      = state_q;
    ring_idx_d   = ring_idx_q;
    snooze_cnt_d = snooze_cnt_q;
    countdown_d  = countdown_q;
    timeout_d    = timeout_q;
    blink_d      = 1'b0;
    pending_d    = (pending_q | new_match) & ~disarm_mask;
    unique case (state_q)
      IDLE: begin
        if (pending_avail != '0) begin
          state_d      = RINGING;
          ring_idx_d   = IDX_W'(lowest_set(8'(pending_avail)));
          pending_d    = pending_d & ~(NUM_ALARMS'(1) << ring_idx_d);
          snooze_cnt_d = '0;
          timeout_d    = '0;
        end
      end
      RINGING: begin
        if (dismiss_evt) begin
          state_d = IDLE;
        end else if (bus.snooze || timeout_hit) begin
          if (snooze_cnt_q < MAX_SNOOZE_C) begin
            state_d      = SNOOZED;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            countdown_d  = SNOOZE_MIN_C;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blink_d = blink_q ^ bus.sec_tick;
          if (bus.sec_tick && (timeout_q != 8'hFF)) timeout_d = timeout_q + 8'd1;
        end
      end
      SNOOZED: begin
        if (dismiss_evt) begin
          state_d = IDLE;
        end else if (bus.min_tick) begin
          if (countdown_q <= 6'd1) begin
            state_d     = RINGING;
            countdown_d = '0;
            timeout_d   = '0;
          end else begin
            countdown_d = countdown_q - 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ring_idx_q   <= '0;
      snooze_cnt_q <= '0;
      countdown_q  <= '0;
      timeout_q    <= '0;
      blink_q      <= 1'b0;
      pending_q    <= '0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_idx_q   <= ring_idx_d;
      snooze_cnt_q <= snooze_cnt_d;
      countdown_q  <= countdown_d;
      timeout_q    <= timeout_d;
      blink_q      <= blink_d;
      pending_q    <= pending_d;
      wr_err_q     <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.wr_err       = wr_err_q;
  assign bus.armed_mask   = slot_armed;
  assign bus.ringing      = (state_q == RINGING);
  assign bus.ring_blink   = blink_q;
  assign bus.ring_idx     = ring_idx_q;
  assign bus.snoozed      = (state_q == SNOOZED);
  assign bus.pending_mask = pending_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl with hand-computed expectations.
// Define ALARM_DAY_MASK_EN on both RTL and bench to exercise the weekday mask.
module tb_multi_alarm_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  multi_alarm_ctrl_if #(.NUM_ALARMS(4), .IDX_W(2)) bus ();

  multi_alarm_ctrl #(
    .NUM_ALARMS(4), .IDX_W(2), .SNOOZE_MIN(5), .MAX_SNOOZE(3), .RING_TIMEOUT_SEC(60)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m);
    bus.cur_hours   = 5'(h);
    bus.cur_minutes = 6'(m);
  endtask

  task automatic wr(input int idx, input int h, input int m, input bit arm);
    bus.wr_en      = 1'b1;
    bus.wr_idx     = 2'(idx);
    bus.wr_hours   = 5'(h);
    bus.wr_minutes = 6'(m);
    bus.wr_arm     = arm;
    tick();
    bus.wr_en      = 1'b0;
  endtask

  task automatic pulse_min();
    bus.min_tick = 1'b1; tick(); bus.min_tick = 1'b0;
  endtask

  task automatic pulse_sec();
    bus.sec_tick = 1'b1; tick(); bus.sec_tick = 1'b0;
  endtask

  task automatic pulse_snooze();
    bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
  endtask

  task automatic pulse_dismiss();
    bus.dismiss = 1'b1; tick(); bus.dismiss = 1'b0;
  endtask

  // Slot 1 is armed at 07:30; a min_tick there queues it, the next cycle rings it.
  task automatic ring_slot1();
    set_time(7, 30);
    pulse_min();
    tick();
  endtask

  initial begin
    bus.sec_tick = 1'b0; bus.min_tick = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0;
    bus.wr_hours = '0; bus.wr_minutes = '0; bus.wr_arm = 1'b0;
    bus.snooze = 1'b0; bus.dismiss = 1'b0;
`ifdef ALARM_DAY_MASK_EN
    bus.cur_day = 3'd0; bus.wr_days = 7'h7F;
`endif
    set_time(0, 0);
    repeat (3) tick();
    chk("rst_ringing", bus.ringing, 0);
    chk("rst_snoozed", bus.snoozed, 0);
    chk("rst_armed", bus.armed_mask, 0);
    chk("rst_pending", bus.pending_mask, 0);
    chk("rst_blink", bus.ring_blink, 0);
    chk("rst_idx", bus.ring_idx, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    rst_n = 1'b1;
    tick();

    // Basic single-slot ring
    wr(1, 7, 30, 1'b1);
    chk("wr_ok_err", bus.wr_err, 0);
    chk("wr_armed", bus.armed_mask, 4'b0010);
    set_time(7, 29);
    pulse_min();
    chk("no_match_0729", bus.pending_mask, 0);
    set_time(7, 30);
    pulse_min();
    chk("match_pending", bus.pending_mask, 4'b0010);
    chk("match_not_yet", bus.ringing, 0);
    tick();
    chk("ring_on", bus.ringing, 1);
    chk("ring_idx1", bus.ring_idx, 1);
    chk("ring_pend_clr", bus.pending_mask, 0);
    chk("blink_start", bus.ring_blink, 0);
    pulse_sec();
    chk("blink_1", bus.ring_blink, 1);
    pulse_sec();
    chk("blink_0", bus.ring_blink, 0);
    pulse_dismiss();
    chk("dismiss_off", bus.ringing, 0);
    chk("dismiss_blink", bus.ring_blink, 0);

    // Rejected writes and time load without min_tick
    wr(0, 24, 0, 1'b1);
    chk("bad_hour_err", bus.wr_err, 1);
    chk("bad_hour_armed", bus.armed_mask, 4'b0010);
    tick();
    chk("err_one_cycle", bus.wr_err, 0);
    wr(0, 6, 60, 1'b1);
    chk("bad_min_err", bus.wr_err, 1);
    chk("bad_min_armed", bus.armed_mask, 4'b0010);
    set_time(7, 29); tick();
    set_time(7, 30); tick(); tick();
    chk("load_no_ring", bus.ringing, 0);
    chk("load_no_pend", bus.pending_mask, 0);

    // Simultaneous matches, lowest index first
    wr(0, 6, 0, 1'b1);
    wr(2, 6, 0, 1'b1);
    chk("three_armed", bus.armed_mask, 4'b0111);
    set_time(6, 0);
    pulse_min();
    chk("dual_pending", bus.pending_mask, 4'b0101);
    tick();
    chk("dual_idx0", bus.ring_idx, 0);
    chk("dual_pend2", bus.pending_mask, 4'b0100);
    pulse_dismiss();
    chk("dual_gap", bus.ringing, 0);
    tick();
    chk("dual_ring2", bus.ringing, 1);
    chk("dual_idx2", bus.ring_idx, 2);
    pulse_dismiss();

    // Snooze limit: three snoozes, fourth acts as dismiss
    ring_slot1();
    chk("snz_ring", bus.ringing, 1);
    set_time(8, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_snooze();
      chk("snz_on", bus.snoozed, 1);
      chk("snz_quiet", bus.ringing, 0);
      repeat (4) pulse_min();
      chk("snz_hold", bus.snoozed, 1);
      pulse_min();
      chk("snz_wake", bus.ringing, 1);
      chk("snz_wake_idx", bus.ring_idx, 1);
    end
    pulse_snooze();
    chk("snz_limit", {bus.ringing, bus.snoozed}, 2'b00);

    // Ring timeout auto-snooze
    ring_slot1();
    repeat (59) pulse_sec();
    chk("tmo_59", bus.ringing, 1);
    pulse_sec();
    chk("tmo_snoozed", bus.snoozed, 1);
    chk("tmo_cnt", dut.snooze_cnt_q, 1);
    pulse_dismiss();
    chk("snz_dismiss", bus.snoozed, 0);

    // Snooze and dismiss together
    ring_slot1();
    bus.snooze = 1'b1; bus.dismiss = 1'b1;
    tick();
    bus.snooze = 1'b0; bus.dismiss = 1'b0;
    chk("both_idle", {bus.ringing, bus.snoozed}, 2'b00);

    // Disarming the active slot dismisses it
    ring_slot1();
    wr(1, 7, 30, 1'b0);
    chk("act_disarm", bus.ringing, 0);
    chk("act_armed", bus.armed_mask, 4'b0101);
    wr(1, 7, 30, 1'b1);

    // Disarming a pending slot drops its request
    set_time(6, 0);
    pulse_min();
    tick();
    chk("pd_idx0", bus.ring_idx, 0);
    wr(2, 6, 0, 1'b0);
    chk("pd_cleared", bus.pending_mask, 0);
    pulse_dismiss();
    tick();
    chk("pd_no_ring", bus.ringing, 0);

    // Asynchronous reset mid-ring
    ring_slot1();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ringing", bus.ringing, 0);
    chk("arst_armed", bus.armed_mask, 0);
    chk("arst_idx", bus.ring_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_rel_armed", bus.armed_mask, 0);
    chk("arst_rel_ring", bus.ringing, 0);

`ifdef ALARM_DAY_MASK_EN
    bus.wr_days = 7'h00;
    wr(3, 9, 0, 1'b1);
    chk("day_zero_err", bus.wr_err, 1);
    bus.wr_days = 7'b0000010;
    wr(3, 9, 0, 1'b1);
    bus.wr_days = 7'h7F;
    set_time(9, 0);
    bus.cur_day = 3'd0;
    pulse_min();
    tick();
    chk("day0_no_ring", bus.ringing, 0);
    bus.cur_day = 3'd1;
    pulse_min();
    chk("day1_pending", bus.pending_mask, 4'b1000);
    tick();
    chk("day1_ring_idx", bus.ring_idx, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_alarm_ctrl.md
Name: multi_alarm_ctrl

Overview:
- Parametrised multi-slot alarm engine for the clock system; supersedes the single-alarm compare/flag logic.
- Holds NUM_ALARMS programmable alarms and compares them against the running time at each minute rollover.
- Arbitrates simultaneous matches and provides snooze with a limited count and a ring timeout.
- Drives ring and blink outputs for the LED and segment display logic.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..8).
- IDX_W, 2, width of slot index (clog2(NUM_ALARMS), min 1).
- SNOOZE_MIN, 5, snooze length in minute ticks (1..63).
- MAX_SNOOZE, 3, snoozes allowed per ring event before a snooze acts as dismiss.
- RING_TIMEOUT_SEC, 60, sec ticks of unattended ringing before auto-snooze (1..255).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- sec_tick, in, 1: one-cycle pulse, once per second.
- min_tick, in, 1: one-cycle pulse on the cycle that cur_hours/cur_minutes show the new minute.
- cur_hours, in, 5: current hour, binary 0..23.
- cur_minutes, in, 6: current minute, binary 0..59.
- wr_en, in, 1: write slot.
- wr_idx, in, IDX_W: slot to write.
- wr_hours, in, 5: alarm hour.
- wr_minutes, in, 6: alarm minute.
- wr_arm, in, 1: slot armed flag.
- snooze, in, 1: debounced one-cycle pulse.
- dismiss, in, 1: debounced one-cycle pulse.
- wr_err, out, 1: one-cycle pulse when a write is rejected.
- armed_mask, out, NUM_ALARMS: armed flag per slot.
- ringing, out, 1: alarm sounding.
- ring_blink, out, 1: toggles on each sec_tick while ringing, otherwise 0.
- ring_idx, out, IDX_W: active slot (valid in RINGING/SNOOZED).
- snoozed, out, 1: in SNOOZED state.
- pending_mask, out, NUM_ALARMS: matched slots waiting to ring.

Behaviour:
- Reset: all slots 00:00 and disarmed; every output 0; state IDLE; all counters 0.
- Write is registered, 1-cycle latency to armed_mask.
- A write with wr_hours>23, wr_minutes>59 or wr_idx>=NUM_ALARMS is ignored and pulses wr_err on the next cycle.
- Match: on min_tick, slot i matches if armed and hours/minutes equal. Matches are evaluated only on min_tick, so loading the time directly onto an alarm value does not trigger it.
- Matched slots are OR-ed into pending_mask.
- States: IDLE, RINGING, SNOOZED.
- IDLE -> RINGING: the cycle after pending_mask is nonzero. Lowest pending index is selected, its pending bit cleared, snooze_cnt=0, timeout counter=0.
- RINGING:
  - ringing=1.
  - dismiss -> IDLE.
  - snooze -> SNOOZED if snooze_cnt<MAX_SNOOZE, otherwise treated as dismiss.
  - RING_TIMEOUT_SEC sec_ticks without input -> same handling as snooze.
- Entering SNOOZED: snooze_cnt++, minute countdown=SNOOZE_MIN.
- SNOOZED:
  - ringing=0, snoozed=1.
  - Countdown decrements on min_tick; at 0 -> RINGING with the same ring_idx and timeout reset.
  - dismiss -> IDLE.
- Dismiss from either state goes to IDLE; if pending_mask is nonzero, RINGING follows next cycle.
- Simultaneous events:
  - dismiss and snooze in the same cycle: dismiss wins.
  - A slot matching while it is the active slot is ignored (no pending bit).
  - Other slots matching during RINGING/SNOOZED queue in pending_mask.
- Write to the active slot:
  - wr_arm=0 acts as dismiss.
  - wr_arm=1 updates the stored time; the ring event continues.
- Write with wr_arm=0 to a pending slot clears its pending bit.
- ring_blink resets to 0 on entering RINGING.
- Arithmetic: counters saturate and never wrap; snooze_cnt width is clog2(MAX_SNOOZE+1).
- Reset asserted mid-ring: immediately IDLE, all outputs 0.

Optional Feature:
- Macro ALARM_DAY_MASK_EN.
- Defined:
  - Adds input cur_day[2:0] (0..6) and input wr_days[6:0].
  - Each slot stores a 7-bit day mask; a match additionally requires mask bit cur_day = 1.
  - A write with wr_days=0 is rejected with wr_err.
  - Reset mask is 7'h7F.
- Undefined: no extra ports; alarms match every day.

Decomposition:
- Package alarm_pkg:
  - state enum {IDLE, RINGING, SNOOZED}.
  - Constants HOURS_MAX=23, MINUTES_MAX=59, HOUR_W=5, MIN_W=6, DAY_W=7.
  - Function for lowest-set-bit index.
- Sub-module alarm_slot: per-slot registers (hours, minutes, arm, optional day mask), write-enable decode input, and combinational match output. Instantiated NUM_ALARMS times in a generate loop.
- FSM, arbitration and counters stay in multi_alarm_ctrl.

Test Plan:
1. Write slot1=07:30 armed; drive time 07:29 then min_tick at 07:30 -> ringing=1 next cycle, ring_idx=1, ring_blink toggles each sec_tick; dismiss -> ringing=0.
2. Write wr_hours=24 or wr_minutes=60 -> wr_err pulse, armed_mask unchanged; load time to 07:30 without min_tick -> no ring.
3. Slots 0 and 2 both 06:00; min_tick at 06:00 -> ring_idx=0, pending_mask=4'b0100; dismiss -> next cycle ring_idx=2.
4. Ringing, MAX_SNOOZE=3: snooze -> snoozed=1; 5 min_ticks -> ringing again. Repeat 3 times; the 4th snooze -> IDLE.
5. Ringing, no input, 60 sec_ticks -> SNOOZED with snooze_cnt=1. Also: snooze+dismiss in the same cycle -> IDLE.
6. Drive rst_n low mid-ring, asynchronously to clk -> all outputs 0 immediately; armed_mask=0 after release. With ALARM_DAY_MASK_EN defined: mask 7'b0000010, cur_day=0 -> no ring; cur_day=1 -> ring.
